// File: rtl/addsub_nibble_seq_pkg.sv
// Shared definitions for the nibble-serial 16-bit adder/subtractor.
// Holds the FSM encoding, the nibble counter width and the saturation limits.
package addsub_nibble_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int CNT_W = 2;

  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;

endpackage

// File: rtl/addsub_nibble_seq_nibble_addsub.sv
// Combinational 4-bit add slice with optional B inversion for subtraction.
// Also exposes the carry into bit 3 so the caller can detect signed overflow.
module nibble_addsub (
  input  logic [3:0] a4,
  input  logic [3:0] b4,
  input  logic       cin,
  input  logic       sub,
  output logic [3:0] s4,
  output logic       cout,
  output logic       c3
);

  logic [3:0] bx;
  logic [3:0] low;
  logic [1:0] top;

  // Split at bit 3 so the carry entering the MSB is observable.
  always_comb begin
    bx   = b4 ^ {4{sub}};
    low  = {1'b0, a4[2:0]} + {1'b0, bx[2:0]} + {3'b000, cin};
    c3   = low[3];
    top  = {1'b0, a4[3]} + {1'b0, bx[3]} + {1'b0, low[3]};
    s4   = {top[0], low[2:0]};
    cout = top[1];
  end

endmodule

// File: rtl/addsub_nibble_seq.sv
// 16-bit signed add/sub that reuses one 4-bit slice over four cycles,
// saturating the result on signed overflow.
module addsub_nibble_seq
  import addsub_nibble_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sub,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        flag_z,
  output logic        flag_n,
  output logic        flag_v,
  output logic [1:0]  state_dbg
);

  // Handshake: start is taken on any edge where busy is low (IDLE or DONE);
  // busy stays high until the last nibble is written, and done is a single
  // cycle pulse marking result/flags valid. start while busy is dropped.

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [15:0]      a_q;
  logic [15:0]      b_q;
  logic             sub_q;
  logic [15:0]      partial;

  logic [3:0]       a4;
  logic [3:0]       b4;
  logic [3:0]       s4;
  logic             cout;
  logic             c3;
  logic             v;
  logic [15:0]      sat_res;

  always_comb begin
    a4 = a_q[3:0];
    b4 = b_q[3:0];
    case (cnt)
      2'd0: begin a4 = a_q[3:0];   b4 = b_q[3:0];   end
      2'd1: begin a4 = a_q[7:4];   b4 = b_q[7:4];   end
      2'd2: begin a4 = a_q[11:8];  b4 = b_q[11:8];  end
      default: begin a4 = a_q[15:12]; b4 = b_q[15:12]; end
    endcase
  end

  nibble_addsub u_slice (
    .a4   (a4),
    .b4   (b4),
    .cin  (carry),
    .sub  (sub_q),
    .s4   (s4),
    .cout (cout),
    .c3   (c3)
  );

  // Only meaningful when cnt==3, where c3/cout belong to bit 15.
  always_comb begin
    v       = c3 ^ cout;
    sat_res = {s4, partial[11:0]};
    if (v) sat_res = a_q[15] ? SAT_NEG : SAT_POS;
  end

  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      carry   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      partial <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      flag_z  <= 1'b0;
      flag_n  <= 1'b0;
      flag_v  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            sub_q <= sub;
            cnt   <= '0;
            carry <= sub;
            busy  <= 1'b1;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          carry <= cout;
          cnt   <= cnt + 1'b1;
          case (cnt)
            2'd0: partial[3:0]   <= s4;
            2'd1: partial[7:4]   <= s4;
            2'd2: partial[11:8]  <= s4;
            default: partial[15:12] <= s4;
          endcase
          if (cnt == 2'd3) begin
            result <= sat_res;
            flag_z <= (sat_res == 16'h0000);
            flag_n <= sat_res[15];
            flag_v <= v;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= ST_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
